// File: rtl/crossy_pkg.sv
// Shared constants and types for the crossy-road playfield blocks.
// Lane configuration is held as a packed {step, dir} pair per lane.
package crossy_pkg;

  localparam int SCREEN_WIDTH = 640;
  localparam int POS_W        = 10;
  localparam int STEP_W       = 3;
  localparam int LANE_W       = 3;

  typedef struct packed {
    logic [STEP_W-1:0] step;
    logic              dir;   // 0 = right (+), 1 = left (-)
  } lane_cfg_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/lane_step_alu.sv
// Combinational wrap-around step: moves one lane position by step pixels
// left or right, keeping the result inside [0, SCREEN_WIDTH-1].
module lane_step_alu
  import crossy_pkg::POS_W, crossy_pkg::STEP_W;
#(
  parameter int SCREEN_WIDTH = crossy_pkg::SCREEN_WIDTH
) (
  input  logic [POS_W-1:0]  pos,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  output logic [POS_W-1:0]  new_pos
);

  localparam logic [POS_W:0]   WIDTH_X = (POS_W+1)'(SCREEN_WIDTH);
  localparam logic [POS_W-1:0] WIDTH_P = POS_W'(SCREEN_WIDTH);

  logic [POS_W:0]   sum_x;
  logic [POS_W-1:0] step_p;

  // Only the overflow test needs the 11-bit sum; the wrapped results are
  // exact in POS_W bits because the true answer always lies below 640.
  always_comb begin
    step_p = {{(POS_W-STEP_W){1'b0}}, step};
    sum_x  = {1'b0, pos} + {{(POS_W+1-STEP_W){1'b0}}, step};
    new_pos = pos;
    if (!dir) begin
      if (sum_x >= WIDTH_X) new_pos = pos + step_p - WIDTH_P;
      else                  new_pos = pos + step_p;
    end else begin
      if (pos < step_p) new_pos = pos + WIDTH_P - step_p;
      else              new_pos = pos - step_p;
    end
  end

endmodule

// File: rtl/lane_scroll_sched.sv
// Obstacle-lane scheduler: a prescaler tick starts a sweep that updates one
// lane per cycle through a single shared lane_step_alu.
module lane_scroll_sched
  import crossy_pkg::POS_W, crossy_pkg::STEP_W, crossy_pkg::LANE_W,
         crossy_pkg::lane_cfg_t, crossy_pkg::sched_state_e,
         crossy_pkg::ST_IDLE, crossy_pkg::ST_UPDATE;
#(
  parameter int N_LANES      = 4,
  parameter int TICK_CYCLES  = 15000,
  parameter int SCREEN_WIDTH = crossy_pkg::SCREEN_WIDTH,
  parameter int RESET_STEP   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pause,
  input  logic                     cfg_we,
  input  logic [LANE_W-1:0]        cfg_lane,
  input  logic [STEP_W-1:0]        cfg_step,
  input  logic                     cfg_dir,
  output logic [POS_W*N_LANES-1:0] h_pos_flat,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic                     state_dbg
);

  localparam int CTR_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IDX_W = $clog2(N_LANES);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TICK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LANES - 1);

  logic [CTR_W-1:0] ctr_q;
  logic             tick;

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] lane_idx_q, lane_idx_d;
  logic             pos_we;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  lane_cfg_t        cfg_q [N_LANES];
  logic [POS_W-1:0] pos_q [N_LANES];
  lane_cfg_t        cur_cfg;
  logic [POS_W-1:0] alu_pos;
  logic             cfg_hit;
  logic [IDX_W-1:0] cfg_idx;

  // Prescaler: a held count survives pause, so release resumes mid-period.
  assign tick = !pause && (ctr_q == CTR_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '0;
    end else if (!pause) begin
      if (ctr_q == CTR_LAST) ctr_q <= '0;
      else                   ctr_q <= ctr_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lane_idx_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  // A tick that lands during a sweep is dropped and latched as overrun.
  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    pos_we     = 1'b0;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d    = ST_UPDATE;
          lane_idx_d = '0;
        end
      end
      ST_UPDATE: begin
        pos_we = 1'b1;
        if (tick) overrun_d = 1'b1;
        if (lane_idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          lane_idx_d = lane_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cfg_we is a single-cycle write strobe with no back-pressure: it is always
  // accepted at the next edge; lane indices beyond N_LANES-1 are discarded.
  assign cfg_hit = cfg_we && (int'(cfg_lane) < N_LANES);
  assign cfg_idx = cfg_lane[IDX_W-1:0];
  assign cur_cfg = cfg_q[lane_idx_q];

  lane_step_alu #(
    .SCREEN_WIDTH(SCREEN_WIDTH)
  ) u_alu (
    .pos     (pos_q[lane_idx_q]),
    .step    (cur_cfg.step),
    .dir     (cur_cfg.dir),
    .new_pos (alu_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_LANES; i++) begin
        pos_q[i] <= '0;
        cfg_q[i] <= '{step: STEP_W'(RESET_STEP), dir: 1'b0};
      end
    end else begin
      if (pos_we)  pos_q[lane_idx_q] <= alu_pos;
      if (cfg_hit) cfg_q[cfg_idx]    <= '{step: cfg_step, dir: cfg_dir};
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_flat
    assign h_pos_flat[POS_W*gi +: POS_W] = pos_q[gi];
  end

  assign busy       = (state_q == ST_UPDATE);
  assign frame_done = done_q;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

endmodule
